// File: rtl/wb_arbiter_pkg.sv
// Shared widths and constants for the register-file write-back path.
package wb_arbiter_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'h0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [REG_BUS_W-1:0]  ZERO_WORD     = 32'h0;

    // One buffered long-latency result: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic [REG_BUS_W-1:0]  wdata;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_lu_fifo.sv
// Small synchronous FIFO for long-latency results.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
// A push while full is ignored, even if a pop happens in the same cycle.
module wb_lu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage is written on push; contents need no reset because empty hides them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; reset discards anything buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline results win, long-latency
// results wait in a FIFO and drain on idle cycles; a starvation counter raises
// stall_req so the pipeline controller inserts a bubble.
// Optional build macro WB_PERF_CNT_EN adds stall_cycles and lu_drops counters.
//
// lu handshake: an entry transfers on a rising edge where lu_valid && lu_ready;
// lu_ready depends only on registered state, and the producer keeps lu_wd/lu_wdata
// stable while lu_valid is high and lu_ready is low.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LU_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wreg,
    input  logic [REG_ADDR_W-1:0] pipe_wd,
    input  logic [REG_BUS_W-1:0]  pipe_wdata,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_wd,
    input  logic [REG_BUS_W-1:0]  lu_wdata,
    output logic                  stall_req,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_BUS_W-1:0]  wdata
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [15:0]           lu_drops
`endif
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_SAT = WC_W'(MAX_WAIT);
    localparam logic [WC_W-1:0] WAIT_ONE = {{(WC_W-1){1'b0}}, 1'b1};

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head_raw;
    wb_entry_t             fifo_head;
    wb_entry_t             lu_entry;
    logic                  lu_accept;
    logic                  lu_push;
    logic                  lu_drop;
    logic                  pipe_req;
    logic                  fifo_pop;
    logic [WC_W-1:0]       wait_cnt;
    logic                  nxt_we;
    logic [REG_ADDR_W-1:0] nxt_waddr;
    logic [REG_BUS_W-1:0]  nxt_wdata;

    assign lu_ready  = !fifo_full;
    assign lu_accept = lu_valid && lu_ready;
    // Writes to r0 are architecturally void: consumed but never buffered or issued.
    assign lu_push   = lu_accept && (lu_wd != NOP_REG_ADDR);
    assign lu_drop   = lu_accept && (lu_wd == NOP_REG_ADDR);
    assign pipe_req  = pipe_wreg && (pipe_wd != NOP_REG_ADDR);
    assign fifo_pop  = !pipe_req && !fifo_empty;
    assign stall_req = (wait_cnt == WAIT_SAT) && !fifo_empty;

    assign lu_entry.wd    = lu_wd;
    assign lu_entry.wdata = lu_wdata;
    assign fifo_head      = wb_entry_t'(fifo_head_raw);

    wb_lu_fifo #(
        .DEPTH (LU_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_data (lu_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head_raw)
    );

    // Select the next write: pipeline first, then FIFO head, else idle holding addr/data.
    always_comb begin
        nxt_we    = WRITE_DISABLE;
        nxt_waddr = waddr;
        nxt_wdata = wdata;
        if (pipe_req) begin
            nxt_we    = WRITE_ENABLE;
            nxt_waddr = pipe_wd;
            nxt_wdata = pipe_wdata;
        end else if (!fifo_empty) begin
            nxt_we    = WRITE_ENABLE;
            nxt_waddr = fifo_head.wd;
            nxt_wdata = fifo_head.wdata;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= WRITE_DISABLE;
            waddr <= NOP_REG_ADDR;
            wdata <= ZERO_WORD;
        end else begin
            we    <= nxt_we;
            waddr <= nxt_waddr;
            wdata <= nxt_wdata;
        end
    end

    // Count consecutive cycles a buffered entry loses to the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end
    end

`ifdef WB_PERF_CNT_EN
    // Stall-cycle counter (wraps) and r0-drop counter (saturates).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            lu_drops     <= '0;
        end else begin
            if (stall_req) stall_cycles <= stall_cycles + 32'd1;
            if (lu_drop && (lu_drops != 16'hFFFF)) lu_drops <= lu_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int LU_DEPTH = 2;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        pipe_wreg;
    logic [4:0]  pipe_wd;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_wd;
    logic [31:0] lu_wdata;
    logic        stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] lu_drops;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [36:0] exp_q[$];
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    int          lost;
    int          exp_stall_cycles;
    int          exp_drops;

    wb_arbiter #(.LU_DEPTH(LU_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_wreg  (pipe_wreg),
        .pipe_wd    (pipe_wd),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_wd      (lu_wd),
        .lu_wdata   (lu_wdata),
        .stall_req  (stall_req),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
`ifdef WB_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .lu_drops     (lu_drops)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_we           = 1'b0;
        exp_waddr        = 5'd0;
        exp_wdata        = 32'd0;
        lost             = 0;
        exp_stall_cycles = 0;
        exp_drops        = 0;
    endtask

    // Drive one cycle of inputs, check pre-edge outputs, advance the model, check results.
    task automatic step(input logic pw, input logic [4:0] pwd, input logic [31:0] pdata,
                        input logic lv, input logic [4:0] lwd, input logic [31:0] ldata,
                        output logic accepted);
        int          sz;
        logic        exp_ready;
        logic        exp_stall;
        logic        pipe_win;
        logic        popped;
        logic [36:0] e;
        pipe_wreg  = pw;
        pipe_wd    = pwd;
        pipe_wdata = pdata;
        lu_valid   = lv;
        lu_wd      = lwd;
        lu_wdata   = ldata;
        #1;
        sz        = exp_q.size();
        exp_ready = (sz < LU_DEPTH);
        exp_stall = (lost == MAX_WAIT) && (sz > 0);
        chk("lu_ready", {31'd0, lu_ready}, {31'd0, exp_ready});
        chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        @(posedge clk);
        accepted = lv && exp_ready;
        pipe_win = pw && (pwd != 5'd0);
        popped   = 1'b0;
        if (pipe_win) begin
            exp_we = 1'b1; exp_waddr = pwd; exp_wdata = pdata;
        end else if (sz > 0) begin
            e = exp_q.pop_front();
            exp_we = 1'b1; exp_waddr = e[36:32]; exp_wdata = e[31:0];
            popped = 1'b1;
        end else begin
            exp_we = 1'b0;
        end
        if (popped || sz == 0) lost = 0;
        else if (pipe_win && lost < MAX_WAIT) lost++;
        if (accepted) begin
            if (lwd != 5'd0) exp_q.push_back({lwd, ldata});
            else if (exp_drops < 65535) exp_drops++;
        end
        if (exp_stall) exp_stall_cycles++;
        #1;
        chk("we", {31'd0, we}, {31'd0, exp_we});
        chk("waddr", {27'd0, waddr}, {27'd0, exp_waddr});
        chk("wdata", wdata, exp_wdata);
`ifdef WB_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, exp_stall_cycles);
        chk("lu_drops", {16'd0, lu_drops}, exp_drops);
`endif
    endtask

    task automatic idle(output logic acc);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic [4:0]  p_wd;
        logic [31:0] p_data;
        int          busy_pct;

        // Test 1: reset with lu_valid held
        rst = 1'b0;
        pipe_wreg = 1'b0; pipe_wd = 5'd0; pipe_wdata = 32'd0;
        lu_valid = 1'b1; lu_wd = 5'd1; lu_wdata = 32'h0000_00A5;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("t1_rst_we", {31'd0, we}, 32'd0);
        chk("t1_rst_waddr", {27'd0, waddr}, 32'd0);
        chk("t1_rst_wdata", wdata, 32'd0);
        chk("t1_rst_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_00A5, acc);
        chk("t1_accept", {31'd0, acc}, 32'd1);
        idle(acc);
        chk("t1_write_r1", {27'd0, waddr}, 32'd1);

        // Test 2: idle pipe, lu push r5
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234_5678, acc);
        chk("t2_accept", {31'd0, acc}, 32'd1);
        chk("t2_no_write_yet", {31'd0, we}, 32'd0);
        idle(acc);
        chk("t2_we", {31'd0, we}, 32'd1);
        chk("t2_waddr", {27'd0, waddr}, 32'd5);
        chk("t2_wdata", wdata, 32'h1234_5678);

        // Test 3: pipeline hogs the port, r7 starves until the bubble
        step(1'b1, 5'd3, 32'h3333_0000, 1'b1, 5'd7, 32'h7777_7777, acc);
        for (int i = 0; i < MAX_WAIT; i++) begin
            chk("t3_stall_low", {31'd0, stall_req}, 32'd0);
            step(1'b1, 5'd3, 32'h3333_0000 + i, 1'b0, 5'd0, 32'd0, acc);
            chk("t3_pipe_wins", {27'd0, waddr}, 32'd3);
        end
        chk("t3_stall_high", {31'd0, stall_req}, 32'd1);
        idle(acc);
        chk("t3_r7_write", {27'd0, waddr}, 32'd7);
        chk("t3_r7_data", wdata, 32'h7777_7777);
        chk("t3_stall_drop", {31'd0, stall_req}, 32'd0);

        // Test 4: fill the FIFO, hold a third entry, drain in order
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'h8888_8888, acc);
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h9999_9999, acc);
        chk("t4_full", {31'd0, lu_ready}, 32'd0);
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hAAAA_AAAA, acc);
        chk("t4_held", {31'd0, acc}, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAAAA_AAAA, acc);
        chk("t4_first_r8", {27'd0, waddr}, 32'd8);
        step(1'b0, 5'd0, 32'd0, acc ? 1'b0 : 1'b1, 5'd10, 32'hAAAA_AAAA, acc);
        chk("t4_second_r9", {27'd0, waddr}, 32'd9);
        repeat (3) idle(acc);

        // Test 5: r0 requests from both sides are ignored
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hCAFE_F00D, acc);
        chk("t5_accept", {31'd0, acc}, 32'd1);
        chk("t5_we", {31'd0, we}, 32'd0);
        idle(acc);
        chk("t5_we_idle", {31'd0, we}, 32'd0);
        chk("t5_ready", {31'd0, lu_ready}, 32'd1);
`ifdef WB_PERF_CNT_EN
        chk("t5_drops", {16'd0, lu_drops}, 32'd1);
`endif

        // Test 6: asynchronous reset with two entries buffered and a write in flight
        step(1'b1, 5'd3, 32'h3, 1'b1, 5'd11, 32'hB, acc);
        step(1'b1, 5'd4, 32'h4, 1'b1, 5'd12, 32'hC, acc);
        chk("t6_we_before", {31'd0, we}, 32'd1);
        pipe_wreg = 1'b0; lu_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_we_clr", {31'd0, we}, 32'd0);
        chk("t6_waddr_clr", {27'd0, waddr}, 32'd0);
        chk("t6_wdata_clr", wdata, 32'd0);
        chk("t6_stall_clr", {31'd0, stall_req}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            idle(acc);
            chk("t6_no_write", {31'd0, we}, 32'd0);
        end

        // Random traffic
        pend = 1'b0; p_wd = 5'd0; p_data = 32'd0; busy_pct = 30;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) busy_pct = (busy_pct == 30) ? 92 : 30;
            if (!pend && $urandom_range(0, 99) < 45) begin
                pend   = 1'b1;
                p_wd   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p_data = $urandom;
            end
            step($urandom_range(0, 99) < busy_pct, 5'($urandom_range(0, 31)), $urandom,
                 pend, p_wd, p_data, acc);
            if (acc) pend = 1'b0;
        end
        repeat (6) idle(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
